// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared constants and width helper for the multiply FSM slice
//
// Holds the default operand width, the derived result width and a constant
// clog2 function used to size pointers and occupancy counters.
package fsm_pkg;

    localparam int DEF_N = 8;
    localparam int RES_W = 2 * DEF_N;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered 0->1 edge detector
//
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (history register clears to 0)
//   d     in   level to watch
//   rise  out  d & ~d_delayed; a level already high when reset releases
//              yields one pulse on the first clock
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/fsm_result_buffer.sv
// rtl/fsm_result_buffer.sv - show-ahead FIFO capturing multiply FSM results
//
// Captures result_i on each rising edge of finished_i and presents entries
// over a valid/ready handshake. Captures arriving while full are dropped
// (unless a pop frees a slot in the same cycle) and flagged via overflow.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   finished_i        upstream finished level
//   result_i [2N]     upstream result, sampled on the finished rising edge
//   out_valid/ready   consumer handshake; out_data [2N] is the head (0 if empty)
//   count             occupancy; full / empty derived from it
//   overflow          sticky drop flag, cleared by clear_ovf (a drop wins)
//   drop_cnt [8]      saturating drop counter, only with RESULT_BUF_DROP_CNT_EN
//   clear_ovf         synchronous clear of overflow (and drop_cnt)
module fsm_result_buffer
    import fsm_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          finished_i,
    input  logic [2*N-1:0]                result_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*N-1:0]                out_data,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
`ifdef RESULT_BUF_DROP_CNT_EN
    output logic [7:0]                    drop_cnt,
`endif
    input  logic                          clear_ovf
);

    localparam int W     = 2 * N;
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic             drop;

    rise_detect u_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (finished_i),
        .rise (push)
    );

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign pop       = out_valid & out_ready;

    // A full FIFO still accepts a capture when the head leaves this cycle.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Storage is intentionally left unreset; out_data masks it while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= result_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef RESULT_BUF_DROP_CNT_EN
    // Clear restarts the count, so a drop in the clearing cycle leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clear_ovf) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fsm_result_buffer.sv
// tb/tb_fsm_result_buffer.sv - scoreboard bench for fsm_result_buffer
module tb_fsm_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        finished_i;
    logic [15:0] result_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        clear_ovf;
`ifdef RESULT_BUF_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];

    fsm_result_buffer #(.N(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .finished_i(finished_i),
        .result_i  (result_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
`ifdef RESULT_BUF_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] data);
        finished_i = 1'b1;
        result_i   = data;
        tick();
        finished_i = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Monitor: every completed handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL sb_unexpected: got %0h expected no entry", out_data);
            end else begin
                chk("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        finished_i = 1'b0;
        result_i   = '0;
        out_ready  = 1'b0;
        clear_ovf  = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single capture with finished held high
        finished_i = 1'b1;
        result_i   = 16'h0305;
        exp_q.push_back(16'h0305);
        tick();
        chk("cap_valid", out_valid, 1);
        chk("cap_data", out_data, 16'h0305);
        chk("cap_count", count, 1);
        repeat (5) tick();
        chk("hold_count", count, 1);
        finished_i = 1'b0;
        tick();

        // Drain
        drain(1);
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 0);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(16'(i));
            pulse(16'(i));
        end
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 1);
`ifdef RESULT_BUF_DROP_CNT_EN
        chk("fill_dropcnt", drop_cnt, 1);
`endif
        drain(4);
        chk("fill_drained", empty, 1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'hA1 + 16'(i));
            pulse(16'hA1 + 16'(i));
            chk("wrap_count", count, 1);
            drain(1);
        end
        chk("wrap_empty", empty, 1);

        // Clear overflow with no drop
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
`ifdef RESULT_BUF_DROP_CNT_EN
        chk("clr_dropcnt", drop_cnt, 0);
`endif

        // Full push + pop in the same cycle
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(16'(i));
            pulse(16'(i));
        end
        chk("fpp_pre_count", count, 4);
        finished_i = 1'b1;
        result_i   = 16'h0009;
        out_ready  = 1'b1;
        exp_q.push_back(16'h0009);
        tick();
        finished_i = 1'b0;
        out_ready  = 1'b0;
        chk("fpp_data", out_data, 2);
        chk("fpp_count", count, 4);
        chk("fpp_ovf", overflow, 0);
        tick();
        drain(4);
        chk("fpp_empty", empty, 1);

        // Drop coinciding with clear: set wins
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'h0011 + 16'(i));
            pulse(16'h0011 + 16'(i));
        end
        pulse(16'h0015);
        chk("drop_ovf", overflow, 1);
        finished_i = 1'b1;
        result_i   = 16'h0016;
        clear_ovf  = 1'b1;
        tick();
        finished_i = 1'b0;
        clear_ovf  = 1'b0;
        chk("setwins_ovf", overflow, 1);
`ifdef RESULT_BUF_DROP_CNT_EN
        chk("setwins_dropcnt", drop_cnt, 1);
`endif
        tick();
        drain(4);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h0031 + 16'(i));
            pulse(16'h0031 + 16'(i));
        end
        chk("pre_rst_count", count, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", overflow, 0);
        exp_q.delete();
        finished_i = 1'b1;
        result_i   = 16'h0077;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.push_back(16'h0077);
        tick();
        chk("post_rst_count", count, 1);
        chk("post_rst_data", out_data, 16'h0077);
        repeat (3) tick();
        chk("post_rst_hold", count, 1);
        finished_i = 1'b0;
        drain(1);
        chk("final_empty", empty, 1);
        chk("sb_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_result_buffer.md
Name: fsm_result_buffer

Overview:
- Downstream stage of the sequential multiply FSM.
- Watches the FSM's `finished` flag and its 2N-bit `result`. On each 0->1 edge of `finished`, it captures `result` into a small show-ahead FIFO.
- It then presents the captured results to the consumer over a valid/ready handshake.
- The FSM never waits on it: results that arrive while the FIFO is full are dropped and flagged.

Parameters:
- N, 8, operand width of the upstream FSM; stored word width is 2*N.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- finished_i  input  1  upstream FSM finished flag (level).
- result_i  input  2*N  upstream FSM result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  2*N  head entry; 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a capture was dropped.
- clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count, finished_q, overflow all go to 0.
  - Outputs go to out_valid=0, out_data=0, empty=1, full=0, overflow=0.
  - FIFO storage is not reset.
- Edge detect:
  - finished_q registers finished_i every cycle.
  - push = finished_i & ~finished_q.
  - A finished_i already high on the first clock after reset release therefore produces exactly one push.
  - A level held high produces one push only.
  - A new push requires finished_i to fall and rise again.
- Capture: on push, result_i is sampled in the same cycle as the rising edge of finished_i.
- Pop: pop = out_valid & out_ready.
- Latency: an entry pushed at edge k is visible at out_data, with out_valid=1, after edge k. This is 1 cycle when the FIFO was empty.
- Show-ahead output: out_data = mem[rd_ptr] when count>0, otherwise 0. out_valid = ~empty. Both are combinational from registers.
- Push/pop/count rules:
  - push & ~full: write mem[wr_ptr], wr_ptr+1.
  - push & full & pop: push accepted and pop performed; count unchanged.
  - push & full & ~pop: word dropped, overflow<=1, pointers and count unchanged.
  - pop alone: rd_ptr+1.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is +1 on accepted push without pop, -1 on pop without push, unchanged otherwise.
- Pop while empty: impossible, since out_valid=0; out_ready is ignored.
- Handshake: out_data and out_valid stay stable while out_valid & ~out_ready. Consumer stalls never affect capture.
- Overflow:
  - Sticky until clear_ovf=1 at a clock edge.
  - If clear_ovf and a new drop happen in the same cycle, overflow stays 1 (set wins).
- Reset mid-operation: asynchronous; all queued entries are discarded, and out_valid falls immediately.

Optional Feature:
- Macro RESULT_BUF_DROP_CNT_EN.
- Defined: adds output drop_cnt, 8 bits.
  - Increments on every dropped push and saturates at 255.
  - Reset to 0; cleared by clear_ovf.
  - Drop and clear in the same cycle gives drop_cnt=1.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fsm_pkg holds:
  - default N;
  - localparam RES_W = 2*N;
  - the function used for pointer/count width (clog2).
- Natural sub-module: rise_detect (1-bit registered edge detector with async active-low reset), reusable for `init` generation elsewhere.
- FIFO storage and pointer logic stay in fsm_result_buffer.

Test Plan:
- Single capture (N=8, DEPTH=4): reset, then finished_i 0->1 with result_i=16'h0305, out_ready=0 -> next cycle out_valid=1, out_data=16'h0305, count=1; finished_i held high 5 cycles -> count stays 1.
- Drain: with the entry above, assert out_ready for 1 cycle -> out_valid=0, out_data=0, empty=1, count=0.
- Fill and overflow: 5 finished pulses with results 1,2,3,4,5, out_ready=0 -> count=4, full=1, overflow=1. Pops return 1,2,3,4 in order, with wrap verified by 3 further push/pop rounds. With RESULT_BUF_DROP_CNT_EN: drop_cnt=1.
- Full push+pop: FIFO full holding 1..4, pulse with result 9 while out_ready=1 -> out_data changes 1->2, count stays 4, overflow unchanged. Final drain yields 2,3,4,9.
- Reset mid-stream: 3 entries queued, rst_n low mid-cycle -> out_valid=0 and count=0 immediately, without waiting for a clock. After release with finished_i high -> exactly one capture.
- Overflow clear: overflow=1, clear_ovf=1 for 1 cycle with no drop -> overflow=0. clear_ovf=1 coinciding with a drop -> overflow stays 1.
